// File: rtl/if_id_buffer_pkg.sv
// Shared encodings and types for the IF/ID buffer: ROM op codes, stall levels,
// issue-tracker states and the {pc, inst} entry carried through the fetch FIFO.
package if_id_buffer_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

    localparam logic RST_ENABLE  = 1'b0;
    localparam logic CHIP_ENABLE = 1'b1;
    localparam logic NO_STOP     = 1'b0;
    localparam logic STOP        = 1'b1;

    typedef enum logic [1:0] {
        PC_ROM_OP_NONE  = 2'b00,
        PC_ROM_OP_READ  = 2'b01,
        PC_ROM_OP_WRITE = 2'b10
    } rom_op_e;

    typedef enum logic [1:0] {
        ISSUE_NONE  = 2'd0,
        ISSUE_FETCH = 2'd1,
        ISSUE_LOAD  = 2'd2
    } issue_kind_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;

    localparam fetch_entry_t BUBBLE = '{pc: '0, inst: NOP_INST};

endpackage

// File: rtl/if_id_buffer_if.sv
// Bundle of the ROM-port, CTRL, ID-side and MEM-side signals around the IF/ID buffer.
interface if_id_buffer_if;
    import if_id_buffer_pkg::*;

    logic              flush;
    logic [5:0]        stall;
    logic [1:0]        rom_op_i;
    logic              ce_i;
    logic [ADDR_W-1:0] pc_i;
    logic [DATA_W-1:0] rom_data_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [DATA_W-1:0] id_inst_o;
    logic              id_valid_o;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_rdata_vld_o;
    logic              overflow_o;

    modport master (
        output flush, stall, rom_op_i, ce_i, pc_i, rom_data_i,
        input  id_pc_o, id_inst_o, id_valid_o, mem_rdata_o, mem_rdata_vld_o, overflow_o
    );

    modport slave (
        input  flush, stall, rom_op_i, ce_i, pc_i, rom_data_i,
        output id_pc_o, id_inst_o, id_valid_o, mem_rdata_o, mem_rdata_vld_o, overflow_o
    );

endinterface

// File: rtl/if_id_buffer_fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries; clear wins over push/pop,
// and a push into a full FIFO is only taken when a pop frees a slot that cycle.
module if_id_buffer_fetch_fifo
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rdata    = mem_q[rd_ptr_q];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= BUBBLE;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID stage: mirrors the fetch sequencer's issue decision, buffers fetched words,
// bypasses straight to ID when idle, and routes EX-initiated ROM reads to MEM.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    if_id_buffer_if.slave bus
);

    issue_kind_e  issue_kind_q, issue_kind_d;
    fetch_entry_t out_q, out_d;
    logic         valid_q, valid_d;
    logic         overflow_q, overflow_d;
    logic         push;
    logic         bypass;
    logic         fifo_push, fifo_pop, fifo_clear;
    logic         fifo_empty, fifo_full;
    fetch_entry_t fifo_rdata;
    fetch_entry_t fetch_word;
    logic         unused_stall;

    assign unused_stall = ^bus.stall[5:3];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            issue_kind_q <= ISSUE_NONE;
        end else begin
            issue_kind_q <= issue_kind_d;
        end
    end

    // A held PC re-presents the same address, so that cycle's word must not be pushed again
    always_comb begin
        issue_kind_d = ISSUE_NONE;
        if (bus.ce_i != CHIP_ENABLE) begin
            issue_kind_d = ISSUE_NONE;
        end else if (bus.flush) begin
            issue_kind_d = ISSUE_FETCH;
        end else if (bus.rom_op_i == PC_ROM_OP_READ) begin
            issue_kind_d = ISSUE_LOAD;
        end else if (bus.rom_op_i == PC_ROM_OP_WRITE) begin
            issue_kind_d = ISSUE_NONE;
        end else if (bus.stall[0] == NO_STOP) begin
            issue_kind_d = ISSUE_FETCH;
        end
    end

    always_comb begin
        push                = (issue_kind_q == ISSUE_FETCH) && !bus.flush;
        bus.mem_rdata_vld_o = (issue_kind_q == ISSUE_LOAD);
        bus.mem_rdata_o     = bus.rom_data_i;
    end

    always_comb begin
        fetch_word = '{pc: bus.pc_i, inst: bus.rom_data_i};
        out_d      = out_q;
        valid_d    = valid_q;
        fifo_clear = 1'b0;
        fifo_pop   = 1'b0;
        bypass     = 1'b0;
        if (bus.flush) begin
            fifo_clear = 1'b1;
            out_d      = BUBBLE;
            valid_d    = 1'b0;
        end else if (bus.stall[1] == STOP && bus.stall[2] == NO_STOP) begin
            out_d   = BUBBLE;
            valid_d = 1'b0;
        end else if (bus.stall[1] == STOP) begin
            out_d   = out_q;
            valid_d = valid_q;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            out_d    = fifo_rdata;
            valid_d  = 1'b1;
        end else if (push) begin
            bypass  = 1'b1;
            out_d   = fetch_word;
            valid_d = 1'b1;
        end else begin
            out_d   = BUBBLE;
            valid_d = 1'b0;
        end
        fifo_push  = push && !bypass;
        overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            out_q      <= BUBBLE;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.id_pc_o    = out_q.pc;
    assign bus.id_inst_o  = out_q.inst;
    assign bus.id_valid_o = valid_q;
    assign bus.overflow_o = overflow_q;

    if_id_buffer_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fetch_word),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
